// File: rtl/div_sequencer.sv
// Multi-cycle floating-point divide sequencer.
// NaN/Inf/zero operand combinations are resolved directly. All other
// operands go through a radix-2 restoring mantissa divide that produces one
// quotient bit per cycle, followed by a single normalisation step. A
// one-cycle done pulse marks the result.
module div_sequencer #(
    parameter int INPUT_INTERFACE_INT_OUT = 24,
    parameter int INPUT_INTERFACE_EXP_OUT = 8,
    parameter int OP_BITS = 2,
    parameter logic [OP_BITS-1:0] OP_DIV = 2'b11
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [OP_BITS-1:0]                 op,
    input  logic [INPUT_INTERFACE_INT_OUT-1:0] outA,
    input  logic [INPUT_INTERFACE_INT_OUT-1:0] outB,
    input  logic [INPUT_INTERFACE_EXP_OUT-1:0] expA,
    input  logic [INPUT_INTERFACE_EXP_OUT-1:0] expB,
    input  logic                               signA,
    input  logic                               signB,
    input  logic                               infA,
    input  logic                               infB,
    input  logic                               zeroA,
    input  logic                               zeroB,
    input  logic                               nanA,
    input  logic                               nanB,
    input  logic                               normalA,
    input  logic                               normalB,
    output logic                               busy,
    output logic                               done,
    output logic [INPUT_INTERFACE_INT_OUT-1:0] result,
    output logic [INPUT_INTERFACE_EXP_OUT-1:0] exp,
    output logic                               sign,
    output logic                               flagNan,
    output logic                               flagInf,
    output logic                               flagZero
);

    localparam int W  = INPUT_INTERFACE_INT_OUT;
    localparam int E  = INPUT_INTERFACE_EXP_OUT;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]  b_mant;
    logic [E-1:0]  a_exp;
    logic [E-1:0]  b_exp;
    logic          sign_lat;
    logic          spec_nan;
    logic          spec_inf;
    logic          spec_zero;
    logic [W:0]    rem;
    logic [W:0]    q;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          eff_zero_a;
    logic          eff_zero_b;
    logic          is_nan;
    logic          is_inf;
    logic          is_zero;
    logic          rem_ge;
    logic [W:0]    rem_sub;
    logic [E-1:0]  exp_diff;

    // A denormal operand (neither normal nor zero) is folded into zero.
    // The special-case decision is made from the live inputs on the
    // accepting cycle and then latched.
    assign accept     = (state == IDLE) && start && (op == OP_DIV);
    assign eff_zero_a = zeroA | ~normalA;
    assign eff_zero_b = zeroB | ~normalB;
    assign is_nan     = nanA | nanB | (infA & infB) | (eff_zero_a & eff_zero_b);
    assign is_inf     = ~is_nan & (infA | eff_zero_b);
    assign is_zero    = ~is_nan & ~is_inf & (eff_zero_a | infB);

    // Restoring divide step. The remainder stays below twice the divisor,
    // so W+1 bits are enough to hold it after the shift.
    assign rem_ge   = (rem >= {1'b0, b_mant});
    assign rem_sub  = rem_ge ? (rem - {1'b0, b_mant}) : rem;
    assign exp_diff = a_exp - b_exp;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (is_nan | is_inf | is_zero) ? SPECIAL : DIVIDE;
                end
            end
            SPECIAL: state_next = DONE;
            DIVIDE: begin
                if (cnt == CW'(W)) begin
                    state_next = NORM;
                end
            end
            NORM:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, divide iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            exp       <= '0;
            sign      <= 1'b0;
            flagNan   <= 1'b0;
            flagInf   <= 1'b0;
            flagZero  <= 1'b0;
            b_mant    <= '0;
            a_exp     <= '0;
            b_exp     <= '0;
            sign_lat  <= 1'b0;
            spec_nan  <= 1'b0;
            spec_inf  <= 1'b0;
            spec_zero <= 1'b0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        busy      <= 1'b1;
                        b_mant    <= outB;
                        a_exp     <= expA;
                        b_exp     <= expB;
                        sign_lat  <= signA ^ signB;
                        spec_nan  <= is_nan;
                        spec_inf  <= is_inf;
                        spec_zero <= is_zero;
                        rem       <= {1'b0, outA};
                        q         <= '0;
                        cnt       <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SPECIAL: begin
                    sign     <= sign_lat;
                    flagNan  <= spec_nan;
                    flagInf  <= spec_inf;
                    flagZero <= spec_zero;
                    if (spec_nan) begin
                        result <= {1'b1, {(W-1){1'b0}}};
                        exp    <= '1;
                    end else if (spec_inf) begin
                        result <= '0;
                        exp    <= '1;
                    end else begin
                        result <= '0;
                        exp    <= '0;
                    end
                end
                DIVIDE: begin
                    rem <= {rem_sub[W-1:0], 1'b0};
                    q   <= {q[W-1:0], rem_ge};
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    sign     <= sign_lat;
                    flagNan  <= 1'b0;
                    flagInf  <= 1'b0;
                    flagZero <= 1'b0;
                    if (q[W]) begin
                        result <= q[W:1];
                        exp    <= exp_diff;
                    end else begin
                        result <= q[W-1:0];
                        exp    <= exp_diff - E'(1);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// operands, compared against an arithmetic reference model.
module tb_div_sequencer;

    localparam int W = 24;
    localparam int E = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [E-1:0] ea;
        logic [E-1:0] eb;
        logic sa, sb;
        logic infa, infb, zeroa, zerob, nana, nanb, norma, normb;
    } opnd_t;

    typedef struct packed {
        logic [W-1:0] result;
        logic [E-1:0] exp;
        logic sign, nan, inf, zero;
        int   lat;
    } expect_t;

    logic clk = 1'b0;
    logic rst, start;
    logic [1:0] op;
    logic [W-1:0] outA, outB;
    logic [E-1:0] expA, expB;
    logic signA, signB, infA, infB, zeroA, zeroB, nanA, nanB, normalA, normalB;
    logic busy, done, sign, flagNan, flagInf, flagZero;
    logic [W-1:0] result;
    logic [E-1:0] exp;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .outA(outA), .outB(outB), .expA(expA), .expB(expB),
        .signA(signA), .signB(signB), .infA(infA), .infB(infB),
        .zeroA(zeroA), .zeroB(zeroB), .nanA(nanA), .nanB(nanB),
        .normalA(normalA), .normalB(normalB),
        .busy(busy), .done(done), .result(result), .exp(exp), .sign(sign),
        .flagNan(flagNan), .flagInf(flagInf), .flagZero(flagZero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic opnd_t mk_norm(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [E-1:0] ea, input logic [E-1:0] eb,
                                      input logic sa, input logic sb);
        opnd_t o;
        o = '0;
        o.a = a; o.b = b; o.ea = ea; o.eb = eb; o.sa = sa; o.sb = sb;
        o.norma = 1'b1; o.normb = 1'b1;
        return o;
    endfunction

    // Reference: quotient = floor(A * 2^W / B), normalised so that the hidden bit lands at the MSB.
    function automatic expect_t model(input opnd_t o);
        expect_t r;
        logic za, zb;
        logic [63:0] quo;
        r = '0;
        r.sign = o.sa ^ o.sb;
        za = o.zeroa | ~o.norma;
        zb = o.zerob | ~o.normb;
        if (o.nana | o.nanb | (o.infa & o.infb) | (za & zb)) begin
            r.nan = 1'b1; r.result = 24'h800000; r.exp = 8'hFF; r.lat = 2;
        end else if (o.infa | zb) begin
            r.inf = 1'b1; r.result = '0; r.exp = 8'hFF; r.lat = 2;
        end else if (za | o.infb) begin
            r.zero = 1'b1; r.result = '0; r.exp = 8'h00; r.lat = 2;
        end else begin
            quo = ({40'd0, o.a} << W) / {40'd0, o.b};
            if (quo >= (64'd1 << W)) begin
                r.result = W'(quo >> 1);
                r.exp    = o.ea - o.eb;
            end else begin
                r.result = W'(quo);
                r.exp    = o.ea - o.eb - 8'd1;
            end
            r.lat = W + 3;
        end
        return r;
    endfunction

    task automatic drive_inputs(input opnd_t o, input logic [1:0] opc);
        op = opc; outA = o.a; outB = o.b; expA = o.ea; expB = o.eb;
        signA = o.sa; signB = o.sb; infA = o.infa; infB = o.infb;
        zeroA = o.zeroa; zeroB = o.zerob; nanA = o.nana; nanB = o.nanb;
        normalA = o.norma; normalB = o.normb;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic apply_stimulus(input opnd_t o, input logic [1:0] opc);
        drive_inputs(o, opc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int first_edge, output int edge_seen);
        edge_seen = 0;
        for (int k = first_edge; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                edge_seen = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input expect_t e, input int edge_seen);
        check_output({tag, ".latency"}, 32'(edge_seen), 32'(e.lat));
        check_output({tag, ".result"}, 32'(result), 32'(e.result));
        check_output({tag, ".exp"}, 32'(exp), 32'(e.exp));
        check_output({tag, ".sign"}, 32'(sign), 32'(e.sign));
        check_output({tag, ".flags"}, 32'({flagNan, flagInf, flagZero}), 32'({e.nan, e.inf, e.zero}));
        check_output({tag, ".busy_at_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_output({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_output({tag, ".busy_drop"}, 32'(busy), 32'd0);
        check_output({tag, ".hold"}, 32'(result), 32'(e.result));
    endtask

    task automatic run_op(input string tag, input opnd_t o);
        expect_t e;
        int seen;
        e = model(o);
        apply_stimulus(o, 2'b11);
        check_output({tag, ".busy_accept"}, 32'(busy), 32'd1);
        wait_done(1, seen);
        check_result(tag, e, seen);
    endtask

    function automatic opnd_t rand_class(input opnd_t base, input bit is_a, input int cls);
        opnd_t o;
        logic inf_f, zero_f, nan_f, norm_f;
        o = base;
        inf_f = 1'b0; zero_f = 1'b0; nan_f = 1'b0; norm_f = 1'b0;
        case (cls)
            0: norm_f = 1'b1;
            1: ;
            2: zero_f = 1'b1;
            3: begin inf_f = 1'b1; norm_f = 1'b1; end
            default: begin nan_f = 1'b1; norm_f = 1'($urandom_range(0, 1)); end
        endcase
        if (is_a) begin
            o.infa = inf_f; o.zeroa = zero_f; o.nana = nan_f; o.norma = norm_f;
        end else begin
            o.infb = inf_f; o.zerob = zero_f; o.nanb = nan_f; o.normb = norm_f;
        end
        return o;
    endfunction

    initial begin
        opnd_t o, o2, c1;
        expect_t e;
        int seen;
        int saw_done;

        rst = 1'b1; start = 1'b0;
        drive_inputs('0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.done", 32'(done), 32'd0);
        check_output("reset.result", 32'(result), 32'd0);
        check_output("reset.exp", 32'(exp), 32'd0);
        check_output("reset.sign_flags", 32'({sign, flagNan, flagInf, flagZero}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        c1 = mk_norm(24'hC00000, 24'h800000, 8'd130, 8'd127, 1'b0, 1'b0);
        run_op("case1_1p5_div_1p0", c1);

        o = mk_norm(24'h800000, 24'hC00000, 8'd127, 8'd127, 1'b1, 1'b0);
        run_op("case2_1p0_div_1p5", o);

        // Reset in the middle of an operation aborts it.
        apply_stimulus(c1, 2'b11);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("midreset.busy_done", 32'({busy, done}), 32'd0);
        check_output("midreset.result", 32'(result), 32'd0);
        check_output("midreset.exp", 32'(exp), 32'd0);
        check_output("midreset.sign_flags", 32'({sign, flagNan, flagInf, flagZero}), 32'd0);
        rst = 1'b0;
        saw_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done++;
        end
        check_output("midreset.no_done", 32'(saw_done), 32'd0);
        run_op("after_reset_case1", c1);

        o = mk_norm(24'h900000, 24'hA00000, 8'd10, 8'd20, 1'b1, 1'b1);
        o.nana = 1'b1; o.zerob = 1'b1; o.infb = 1'b1;
        run_op("case3_nanA", o);
        o = mk_norm(24'h800000, 24'h800000, 8'd1, 8'd2, 1'b0, 1'b1);
        o.zeroa = 1'b1; o.norma = 1'b0; o.zerob = 1'b1; o.normb = 1'b0;
        run_op("case3_zero_zero", o);
        o = mk_norm(24'hABCDEF, 24'h800000, 8'd50, 8'd40, 1'b1, 1'b0);
        o.zerob = 1'b1; o.normb = 1'b0;
        run_op("case4_div_by_zero", o);
        o = mk_norm(24'h123456, 24'hF00000, 8'd0, 8'd9, 1'b0, 1'b0);
        o.norma = 1'b0;
        run_op("case4_denormA", o);

        // A second start while busy must be ignored.
        e = model(c1);
        apply_stimulus(c1, 2'b11);
        repeat (4) begin @(posedge clk); #1; end
        o2 = mk_norm(24'hFFFFFF, 24'h812345, 8'd3, 8'd200, 1'b1, 1'b0);
        drive_inputs(o2, 2'b11);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, seen);
        check_result("case5_ignored_start", e, seen);

        // A start with a non-divide op code is not accepted.
        apply_stimulus(o2, 2'b01);
        check_output("case5_wrong_op.busy", 32'(busy), 32'd0);
        saw_done = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done++;
        end
        check_output("case5_wrong_op.no_done", 32'(saw_done), 32'd0);

        for (int i = 0; i < 16; i++) begin
            o = mk_norm(W'($urandom) | 24'h800000, W'($urandom) | 24'h800000,
                        E'($urandom), E'($urandom), 1'($urandom), 1'($urandom));
            run_op($sformatf("rand_norm%0d", i), o);
        end

        for (int i = 0; i < 16; i++) begin
            o = mk_norm(W'($urandom) | 24'h800000, W'($urandom) | 24'h800000,
                        E'($urandom), E'($urandom), 1'($urandom), 1'($urandom));
            o = rand_class(o, 1'b1, $urandom_range(0, 4));
            o = rand_class(o, 1'b0, $urandom_range(0, 4));
            run_op($sformatf("rand_class%0d", i), o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
